store_pack_unit: RTL and testbench

Store-path narrowing unit for the MEM stage: the write-side counterpart of the load/immediate extension logic. It accepts a 32-bit register value, a byte address and a store width (SB/SH/SW), and replicates the value into the correct byte lanes. It generates byte enables and a word-aligned address, and buffers up to two stores toward data memory under a valid/ready handshake. Misaligned or illegal stores are rejected with a one-cycle exception pulse.

---
 rtl/store_pack_unit.sv | 157 +++++++++++++++
 tb/tb_store_pack_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/store_pack_unit.sv
// MEM-stage store packer: lane replication, byte enables and a
// two-entry store buffer toward data memory with fault reporting.
module store_pack_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  output logic              exc_valid,
  output logic [ADDR_W-1:0] exc_addr,
  output logic [1:0]        exc_cause,
  output logic              busy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [31:0]       pk_wdata;
  logic [3:0]        pk_be;
  logic              fault;
  logic [1:0]        cause;
  logic [ADDR_W-1:0] al_addr;
  logic              take;
  logic              acc;
  logic              flt;
  logic              drain;

  logic [ADDR_W-1:0] sk_addr;
  logic [31:0]       sk_wdata;
  logic [3:0]        sk_be;

  assign al_addr = {req_addr[ADDR_W-1:2], 2'b00};

  always_comb begin
    pk_wdata = req_data;
    pk_be    = 4'b0000;
    fault    = 1'b0;
    cause    = 2'b00;
    unique case (req_op)
      2'b00: begin
        pk_wdata = {4{req_data[7:0]}};
        pk_be    = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        pk_wdata = {2{req_data[15:0]}};
        pk_be    = req_addr[1] ? 4'b1100 : 4'b0011;
        fault    = req_addr[0];
        cause    = 2'b01;
      end
      2'b10: begin
        pk_be = 4'b1111;
        fault = (req_addr[1:0] != 2'b00);
        cause = 2'b10;
      end
      default: begin
        fault = 1'b1;
        cause = 2'b11;
      end
    endcase
  end

  assign take  = req_valid && req_ready;
  assign acc   = take && !fault;
  assign flt   = take && fault;
  assign drain = mem_valid && mem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      EMPTY: if (acc) state_nx = ONE;
      ONE: begin
        if (acc && !drain)      state_nx = FULL;
        else if (!acc && drain) state_nx = EMPTY;
      end
      FULL:    if (drain) state_nx = ONE;
      default: state_nx = EMPTY;
    endcase
  end

  always_comb begin
    req_ready = (state != FULL);
    busy      = (state != EMPTY);
    mem_valid = (state != EMPTY);
  end

  // Head loads a new request whenever it is (or is about to become)
  // free; in FULL the skid entry moves up on drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      sk_addr   <= '0;
      sk_wdata  <= '0;
      sk_be     <= '0;
    end else begin
      unique case (state)
        EMPTY: if (acc) begin
          mem_addr  <= al_addr;
          mem_wdata <= pk_wdata;
          mem_be    <= pk_be;
        end
        ONE: begin
          if (acc && drain) begin
            mem_addr  <= al_addr;
            mem_wdata <= pk_wdata;
            mem_be    <= pk_be;
          end else if (acc) begin
            sk_addr  <= al_addr;
            sk_wdata <= pk_wdata;
            sk_be    <= pk_be;
          end
        end
        FULL: if (drain) begin
          mem_addr  <= sk_addr;
          mem_wdata <= sk_wdata;
          mem_be    <= sk_be;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exc_valid <= 1'b0;
      exc_addr  <= '0;
      exc_cause <= 2'b00;
    end else begin
      exc_valid <= flt;
      if (flt) begin
        exc_addr  <= req_addr;
        exc_cause <= cause;
      end
    end
  end

endmodule

// File: tb/tb_store_pack_unit.sv
// Directed bench for store_pack_unit: packing, faults,
// backpressure, streaming and asynchronous reset.
module tb_store_pack_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        exc_valid;
  logic [31:0] exc_addr;
  logic [1:0]  exc_cause;
  logic        busy;

  int checks = 0;
  int errors = 0;

  store_pack_unit #(.ADDR_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .exc_valid (exc_valid),
    .exc_addr  (exc_addr),
    .exc_cause (exc_cause),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] d);
    req_valid = v;
    req_op    = op;
    req_addr  = a;
    req_data  = d;
  endtask

  initial begin
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    #12;
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_exc_valid", exc_valid, 0);
    chk("rst_exc_addr", exc_addr, 0);
    chk("rst_exc_cause", exc_cause, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_be", mem_be, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_req_ready", req_ready, 1);
    tick();

    // SB sweep
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'b00, 32'h100 + i, 32'hAABBCCDD);
      tick();
      chk("sb_valid", mem_valid, 1);
      chk("sb_addr", mem_addr, 32'h100);
      chk("sb_wdata", mem_wdata, 32'hDDDDDDDD);
      chk("sb_be", mem_be, 4'b0001 << i);
    end
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    tick();
    chk("sb_idle", mem_valid, 0);

    // SH / SW aligned
    drive(1'b1, 2'b01, 32'h202, 32'h1234ABCD);
    tick();
    chk("sh_valid", mem_valid, 1);
    chk("sh_addr", mem_addr, 32'h200);
    chk("sh_wdata", mem_wdata, 32'hABCDABCD);
    chk("sh_be", mem_be, 4'b1100);
    drive(1'b1, 2'b10, 32'h204, 32'h1234ABCD);
    tick();
    chk("sw_addr", mem_addr, 32'h204);
    chk("sw_wdata", mem_wdata, 32'h1234ABCD);
    chk("sw_be", mem_be, 4'b1111);
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    tick();
    chk("sw_idle", mem_valid, 0);

    // back-to-back faults
    drive(1'b1, 2'b01, 32'h301, 32'h55);
    tick();
    chk("fh_exc", exc_valid, 1);
    chk("fh_cause", exc_cause, 2'b01);
    chk("fh_addr", exc_addr, 32'h301);
    chk("fh_nomem", mem_valid, 0);
    drive(1'b1, 2'b10, 32'h302, 32'h55);
    tick();
    chk("fw_exc", exc_valid, 1);
    chk("fw_cause", exc_cause, 2'b10);
    chk("fw_addr", exc_addr, 32'h302);
    chk("fw_nomem", mem_valid, 0);
    drive(1'b1, 2'b11, 32'h400, 32'h55);
    tick();
    chk("fi_exc", exc_valid, 1);
    chk("fi_cause", exc_cause, 2'b11);
    chk("fi_addr", exc_addr, 32'h400);
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    tick();
    chk("f_pulse_end", exc_valid, 0);
    chk("f_addr_held", exc_addr, 32'h400);
    chk("f_nomem", mem_valid, 0);

    // backpressure
    mem_ready = 1'b0;
    drive(1'b1, 2'b10, 32'h500, 32'h11111111);
    tick();
    chk("bp_a_valid", mem_valid, 1);
    chk("bp_a_addr", mem_addr, 32'h500);
    chk("bp_a_ready", req_ready, 1);
    drive(1'b1, 2'b10, 32'h504, 32'h22222222);
    tick();
    chk("bp_full_ready", req_ready, 0);
    chk("bp_full_busy", busy, 1);
    chk("bp_head_hold", mem_addr, 32'h500);
    drive(1'b1, 2'b10, 32'h508, 32'h33333333);
    tick();
    chk("bp_c_blocked", req_ready, 0);
    chk("bp_head_addr", mem_addr, 32'h500);
    chk("bp_head_data", mem_wdata, 32'h11111111);
    chk("bp_head_valid", mem_valid, 1);
    mem_ready = 1'b1;
    tick();
    chk("bp_b_addr", mem_addr, 32'h504);
    chk("bp_b_data", mem_wdata, 32'h22222222);
    chk("bp_b_ready", req_ready, 1);
    tick();
    chk("bp_c_addr", mem_addr, 32'h508);
    chk("bp_c_data", mem_wdata, 32'h33333333);
    chk("bp_c_valid", mem_valid, 1);
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    tick();
    chk("bp_empty", mem_valid, 0);
    chk("bp_busy", busy, 0);

    // streaming
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 2'b10, 32'h600 + 4 * i, 32'hC0DE0000 + i);
      tick();
      chk("st_valid", mem_valid, 1);
      chk("st_addr", mem_addr, 32'h600 + 4 * i);
      chk("st_wdata", mem_wdata, 32'hC0DE0000 + i);
      chk("st_ready", req_ready, 1);
    end
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    tick();
    chk("st_empty", mem_valid, 0);

    // async reset while FULL
    mem_ready = 1'b0;
    drive(1'b1, 2'b10, 32'h700, 32'h77777777);
    tick();
    drive(1'b1, 2'b10, 32'h704, 32'h88888888);
    tick();
    chk("ar_full", req_ready, 0);
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_mem_valid", mem_valid, 0);
    chk("ar_busy", busy, 0);
    chk("ar_mem_be", mem_be, 0);
    #7;
    rst_n = 1'b1;
    mem_ready = 1'b1;
    tick();
    chk("ar_no_write", mem_valid, 0);
    chk("ar_ready", req_ready, 1);
    tick();
    chk("ar_no_write2", mem_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
